// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the multiplexed 7-segment scanner
//   scan_state_e : scan FSM states (IDLE, DEAD, ON, OFF)
//   SEG_*        : bit positions inside the {dp,g,f,e,d,c,b,a} segment word
//   HEX7         : hex nibble -> {g,f,e,d,c,b,a} active-high pattern
//   NUM_DIGITS   : digits on the display, FIELD_W : bits per digit field
package seg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DEAD, ST_ON, ST_OFF} scan_state_e;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam int NUM_DIGITS = 4;
  localparam int FIELD_W = 5;
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble + decimal point -> active-high 8-bit segment pattern
//   i_nib [3:0] : hex digit
//   i_dp        : decimal point, drives segment SEG_DP directly
//   o_seg [7:0] : {dp,g,f,e,d,c,b,a}, 1 = lit
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);
  always_comb begin
    o_seg = {1'b0, HEX7[i_nib]};
    o_seg[SEG_DP] = i_dp;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed display scanner with dead time, brightness duty and double-buffered data
//   i_CLK, i_RST       : clock, synchronous active-high reset
//   i_EN               : scan enable
//   i_VALID/o_READY    : handshake for a new 20-bit display word on i_DATA
//   i_DATA [19:0]      : digit n = [5n+4:5n] = {dp, nibble}, digit 0 rightmost
//   i_BRIGHT [3:0]     : lit ticks per slot, sampled at each slot start
//   o_DRAINS [3:0]     : one-hot digit drain (polarity DRAIN_ACT_LOW)
//   o_LEDS [7:0]       : {dp,g,f,e,d,c,b,a} (polarity SEG_ACT_LOW)
//   o_FRAME            : one-cycle pulse when the displayed word is reloaded
// Build option LEADING_ZERO_BLANK_EN: darkens zero-valued leading digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 12000,
  parameter int DEAD_TICKS = 2,
  parameter int DRAIN_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_EN,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [19:0] i_DATA,
  input  logic [3:0]  i_BRIGHT,
  output logic [3:0]  o_DRAINS,
  output logic [7:0]  o_LEDS,
  output logic        o_FRAME
);
  localparam int SLOT = DEAD_TICKS + 15;
  localparam int PW = $clog2(CLK_DIV);
  localparam int TW = $clog2(SLOT);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(SLOT - 1);
  localparam logic [TW-1:0] T_DEAD = TW'(DEAD_TICKS);
  localparam logic [3:0] DRAIN_OFF = DRAIN_ACT_LOW != 0 ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW != 0 ? 8'hFF : 8'h00;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] t_q, t_d, rel;
  logic [1:0] dig_q, dig_d;
  scan_state_e st_q, st_d;
  logic [3:0] bright_q, bright_d;
  logic [NUM_DIGITS*FIELD_W-1:0] active_q, active_d, pend_q, pend_d;
  logic full_q, full_d, frame_q, frame_d;
  logic [3:0] drains_q, drains_d;
  logic [7:0] leds_q, leds_d, seg;
  logic [FIELD_W-1:0] field;
  logic tick, slot_end, xfer, blank;
  // Counters and state are computed as next-state values so the registered
  // outputs line up with the registered counters in the same cycle.
  always_comb begin
    pre_d = pre_q;
    t_d = t_q;
    dig_d = dig_q;
    bright_d = bright_q;
    active_d = active_q;
    pend_d = pend_q;
    full_d = full_q;
    frame_d = 1'b0;
    xfer = 1'b0;
    tick = pre_q == PRE_MAX;
    slot_end = tick && t_q == T_LAST;
    if (!i_EN) begin
      pre_d = '0;
      t_d = '0;
      dig_d = '0;
      xfer = full_q;
    end else if (st_q == ST_IDLE) begin
      bright_d = i_BRIGHT;
    end else begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      t_d = slot_end ? '0 : t_q + TW'(tick);
      dig_d = dig_q + 2'(slot_end);
      bright_d = slot_end ? i_BRIGHT : bright_q;
      xfer = slot_end && dig_q == 2'd3 && full_q;
    end
    rel = t_d - T_DEAD;
    st_d = !i_EN ? ST_IDLE : t_d < T_DEAD ? ST_DEAD : rel < TW'(bright_d) ? ST_ON : ST_OFF;
    // Accept needs an empty buffer and a transfer needs a full one, so the two never collide.
    if (xfer) begin
      active_d = pend_q;
      full_d = 1'b0;
      frame_d = 1'b1;
    end
    if (i_VALID && !full_q) begin
      pend_d = i_DATA;
      full_d = 1'b1;
    end
  end
  assign field = active_d[dig_d*FIELD_W +: FIELD_W];
`ifdef LEADING_ZERO_BLANK_EN
  // Blank when this digit and every digit above it is all-zero (nibble and dp).
  assign blank = dig_d != 2'd0 && (active_d >> (dig_d*FIELD_W)) == '0;
`else
  assign blank = 1'b0;
`endif
  seg7_decode u_dec (
    .i_nib(field[3:0]),
    .i_dp (field[4]),
    .o_seg(seg)
  );
  // Drain stays on through ON and OFF, so it only switches around DEAD with segments unlit.
  always_comb begin
    drains_d = ((st_d == ST_ON || st_d == ST_OFF) ? 4'(1) << dig_d : 4'h0) ^ DRAIN_OFF;
    leds_d = ((st_d == ST_ON && !blank) ? seg : 8'h00) ^ SEG_OFF;
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pre_q <= '0;
      t_q <= '0;
      dig_q <= '0;
      st_q <= ST_IDLE;
      bright_q <= '0;
      active_q <= '0;
      pend_q <= '0;
      full_q <= 1'b0;
      frame_q <= 1'b0;
      drains_q <= DRAIN_OFF;
      leds_q <= SEG_OFF;
    end else begin
      pre_q <= pre_d;
      t_q <= t_d;
      dig_q <= dig_d;
      st_q <= st_d;
      bright_q <= bright_d;
      active_q <= active_d;
      pend_q <= pend_d;
      full_q <= full_d;
      frame_q <= frame_d;
      drains_q <= drains_d;
      leds_q <= leds_d;
    end
  end
  assign o_READY = !full_q;
  assign o_DRAINS = drains_q;
  assign o_LEDS = leds_q;
  assign o_FRAME = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed + randomized bench for seg_scan_ctrl against a cycle-count reference model
module tb_seg_scan_ctrl;
  localparam int CLK_DIV = 4;
  localparam int DEAD = 2;
  localparam int SLOT_CYC = (DEAD + 15) * CLK_DIV;
  localparam int FRAME_CYC = 4 * SLOT_CYC;
  localparam logic [6:0] HEX7_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic valid = 1'b0;
  logic [19:0] data = '0;
  logic [3:0] bright = 4'd15;
  logic ready, frame;
  logic [3:0] drains;
  logic [7:0] leds;
  int total = 0;
  int bad = 0;
  bit armed = 1'b0;
  seg_scan_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DEAD_TICKS(DEAD),
    .DRAIN_ACT_LOW(1),
    .SEG_ACT_LOW(0)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .i_EN(en),
    .i_VALID(valid),
    .o_READY(ready),
    .i_DATA(data),
    .i_BRIGHT(bright),
    .o_DRAINS(drains),
    .o_LEDS(leds),
    .o_FRAME(frame)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  // Reference model: position k in the frame counts cycles since the scan started.
  bit m_scan = 1'b0;
  bit m_full = 1'b0;
  bit m_frame = 1'b0;
  int m_k = 0;
  logic [3:0] m_br = '0;
  logic [19:0] m_act = '0;
  logic [19:0] m_pend = '0;
  always @(posedge clk) begin
    logic [19:0] old_pend;
    bit old_full, xfer;
    old_pend = m_pend;
    old_full = m_full;
    xfer = 1'b0;
    m_frame = 1'b0;
    if (rst) begin
      m_scan = 1'b0;
      m_k = 0;
      m_full = 1'b0;
      m_act = '0;
    end else begin
      if (!en) begin
        m_scan = 1'b0;
        m_k = 0;
        xfer = old_full;
      end else if (!m_scan) begin
        m_scan = 1'b1;
        m_k = 0;
        m_br = bright;
      end else begin
        xfer = (m_k == FRAME_CYC - 1) && old_full;
        m_k = (m_k + 1) % FRAME_CYC;
        if (m_k % SLOT_CYC == 0) m_br = bright;
      end
      if (xfer) begin
        m_act = old_pend;
        m_full = 1'b0;
        m_frame = 1'b1;
      end
      if (valid && !old_full) begin
        m_pend = data;
        m_full = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    int dig, t;
    logic [3:0] ed;
    logic [7:0] el;
    logic [4:0] f;
    bit blank;
    if (armed) begin
      ed = 4'hF;
      el = '0;
      if (m_scan) begin
        dig = m_k / SLOT_CYC;
        t = (m_k % SLOT_CYC) / CLK_DIV;
        f = m_act[dig*5 +: 5];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = dig > 0;
        for (int j = 0; j < 4; j++) if (j >= dig && m_act[j*5 +: 5] != 0) blank = 1'b0;
`endif
        if (t >= DEAD) ed = ~(4'b0001 << dig);
        if (t >= DEAD && t - DEAD < int'(m_br) && !blank) el = {f[4], HEX7_REF[f[3:0]]};
      end
      check("drains", drains, ed);
      check("leds", leds, el);
      check("frame", frame, m_frame);
      check("ready", ready, !m_full);
    end
  end
  task automatic send(input logic [19:0] d);
    int n = 0;
    valid = 1'b1;
    data = d;
    while (!ready && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1);
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic wait_frame();
    int n = 0;
    while (!frame && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check("frame_seen", frame, 1);
    @(negedge clk);
  endtask
  task automatic count_frame(output int lit, output int on);
    lit = 0;
    on = 0;
    repeat (FRAME_CYC) begin
      @(negedge clk);
      if (leds != 0) lit++;
      if (drains != 4'hF) on++;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int lit, on, n;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    check("rst_ready", ready, 1);
    check("rst_drains", drains, 4'hF);
    check("rst_leds", leds, 8'h00);
    rst = 1'b0;
    en = 1'b1;
    send(20'h04321);
    wait_frame();
    count_frame(lit, on);
    check("lit_b15", lit, 240);
    check("on_b15", on, 240);
    bright = 4'd5;
    repeat (SLOT_CYC + 2) @(negedge clk);
    count_frame(lit, on);
    check("lit_b5", lit, 80);
    check("on_b5", on, 240);
    bright = 4'd0;
    repeat (SLOT_CYC + 2) @(negedge clk);
    count_frame(lit, on);
    check("lit_b0", lit, 0);
    check("on_b0", on, 240);
    bright = 4'd9;
    send(20'h1A2B3);
    send(20'hC8D07);
    check("b_held", ready, 0);
    wait_frame();
    n = 0;
    while (!(m_scan && m_k == 2 * SLOT_CYC + 30) && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check("dig2_drain", drains, 4'b1011);
    en = 1'b0;
    @(negedge clk);
    check("en_off_drains", drains, 4'hF);
    check("en_off_leds", leds, 8'h00);
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (8) @(negedge clk);
    check("restart_dead", drains, 4'hF);
    @(negedge clk);
    check("restart_drain0", drains, 4'b1110);
    send(20'h0ABCD);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_ready", ready, 1);
    check("rst2_drains", drains, 4'hF);
    check("rst2_leds", leds, 8'h00);
    rst = 1'b0;
    count_frame(lit, on);
`ifdef LEADING_ZERO_BLANK_EN
    check("lit_zero_word", lit, 36);
`else
    check("lit_zero_word", lit, 144);
`endif
    send(20'h00005);
    bright = 4'd15;
    wait_frame();
    repeat (SLOT_CYC + 2) @(negedge clk);
    count_frame(lit, on);
`ifdef LEADING_ZERO_BLANK_EN
    check("lit_lzb", lit, 60);
`else
    check("lit_lzb", lit, 240);
`endif
    check("on_lzb", on, 240);
    repeat (3000) begin
      @(negedge clk);
      rst = $urandom_range(0, 999) == 0;
      if (en ? $urandom_range(0, 299) == 0 : $urandom_range(0, 19) == 0) en = !en;
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
      valid = $urandom_range(0, 3) == 0;
      if (valid) data = 20'($urandom);
    end
    valid = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
